composite_bus_slice: RTL and testbench

- Registered pipeline slice for the five-channel composite bus (addr_read, addr_write, data_read, data_write, resp_write) between side_a (initiator) and side_b (target).
- Every channel passes through an independent 2-entry skid buffer, giving full throughput and cutting all combinational valid/ready paths.
- Adds a parametrised outstanding-write limiter on addr_write/resp_write.
- Sits between interconnect stages wherever timing closure needs a register boundary.

---
 rtl/composite_bus_slice.sv | 170 +++++++++++++++++
 tb/tb_composite_bus_slice.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/composite_bus_slice.sv
// Registered five-channel bus slice: 2-entry skid buffer per channel plus an outstanding-write limiter.
// Optional COMPOSITE_BUS_SLICE_PERF_EN adds the perf_limit_stall counter output.
module composite_bus_slice_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);
  logic [W-1:0] skid_data;
  logic         skid_vld;
  logic         in_fire, out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // in_ready is its own register so it stays low through reset and rises on the first edge after.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      skid_vld  <= 1'b0;
      skid_data <= '0;
      in_ready  <= 1'b0;
    end else begin
      in_ready <= 1'b1;
      if (skid_vld) begin
        if (out_fire) begin
          out_data <= skid_data;
          skid_vld <= 1'b0;
        end else begin
          in_ready <= 1'b0;
        end
      end else if (!out_valid || out_fire) begin
        out_valid <= in_fire;
        if (in_fire) out_data <= in_data;
      end else if (in_fire) begin
        skid_data <= in_data;
        skid_vld  <= 1'b1;
        in_ready  <= 1'b0;
      end
    end
  end
endmodule

module composite_bus_slice #(
  parameter int ADDR_W          = 8,
  parameter int DATA_W          = 8,
  parameter int RESP_W          = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] side_a_addr_read_bus_data,
  input  logic              side_a_addr_read_bus_valid,
  output logic              side_a_addr_read_bus_ready,
  input  logic [ADDR_W-1:0] side_a_addr_write_bus_data,
  input  logic              side_a_addr_write_bus_valid,
  output logic              side_a_addr_write_bus_ready,
  input  logic [DATA_W-1:0] side_a_data_write_bus_data,
  input  logic              side_a_data_write_bus_valid,
  output logic              side_a_data_write_bus_ready,
  output logic [DATA_W-1:0] side_a_data_read_bus_data,
  output logic              side_a_data_read_bus_valid,
  input  logic              side_a_data_read_bus_ready,
  output logic [RESP_W-1:0] side_a_resp_write_bus_data,
  output logic              side_a_resp_write_bus_valid,
  input  logic              side_a_resp_write_bus_ready,
  output logic [ADDR_W-1:0] side_b_addr_read_bus_data,
  output logic              side_b_addr_read_bus_valid,
  input  logic              side_b_addr_read_bus_ready,
  output logic [ADDR_W-1:0] side_b_addr_write_bus_data,
  output logic              side_b_addr_write_bus_valid,
  input  logic              side_b_addr_write_bus_ready,
  output logic [DATA_W-1:0] side_b_data_write_bus_data,
  output logic              side_b_data_write_bus_valid,
  input  logic              side_b_data_write_bus_ready,
  input  logic [DATA_W-1:0] side_b_data_read_bus_data,
  input  logic              side_b_data_read_bus_valid,
  output logic              side_b_data_read_bus_ready,
  input  logic [RESP_W-1:0] side_b_resp_write_bus_data,
  input  logic              side_b_resp_write_bus_valid,
  output logic              side_b_resp_write_bus_ready,
  output logic              err_resp_underflow
`ifdef COMPOSITE_BUS_SLICE_PERF_EN
  ,
  output logic [15:0]       perf_limit_stall
`endif
);
  localparam int            CW    = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);

  logic [CW-1:0] cnt, cnt_nxt;
  logic          at_max_q;
  logic          aw_space;
  logic          aw_fire, b_fire;

  // Gating valid (not just ready) keeps the skid from capturing a beat the limiter refused.
  composite_bus_slice_skid #(.W(ADDR_W)) u_ar (
    .clk, .rst,
    .in_data  (side_a_addr_read_bus_data),  .in_valid (side_a_addr_read_bus_valid),
    .in_ready (side_a_addr_read_bus_ready),
    .out_data (side_b_addr_read_bus_data),  .out_valid(side_b_addr_read_bus_valid),
    .out_ready(side_b_addr_read_bus_ready));

  composite_bus_slice_skid #(.W(ADDR_W)) u_aw (
    .clk, .rst,
    .in_data  (side_a_addr_write_bus_data),
    .in_valid (side_a_addr_write_bus_valid & ~at_max_q),
    .in_ready (aw_space),
    .out_data (side_b_addr_write_bus_data), .out_valid(side_b_addr_write_bus_valid),
    .out_ready(side_b_addr_write_bus_ready));

  composite_bus_slice_skid #(.W(DATA_W)) u_w (
    .clk, .rst,
    .in_data  (side_a_data_write_bus_data), .in_valid (side_a_data_write_bus_valid),
    .in_ready (side_a_data_write_bus_ready),
    .out_data (side_b_data_write_bus_data), .out_valid(side_b_data_write_bus_valid),
    .out_ready(side_b_data_write_bus_ready));

  composite_bus_slice_skid #(.W(DATA_W)) u_r (
    .clk, .rst,
    .in_data  (side_b_data_read_bus_data),  .in_valid (side_b_data_read_bus_valid),
    .in_ready (side_b_data_read_bus_ready),
    .out_data (side_a_data_read_bus_data),  .out_valid(side_a_data_read_bus_valid),
    .out_ready(side_a_data_read_bus_ready));

  composite_bus_slice_skid #(.W(RESP_W)) u_b (
    .clk, .rst,
    .in_data  (side_b_resp_write_bus_data), .in_valid (side_b_resp_write_bus_valid),
    .in_ready (side_b_resp_write_bus_ready),
    .out_data (side_a_resp_write_bus_data), .out_valid(side_a_resp_write_bus_valid),
    .out_ready(side_a_resp_write_bus_ready));

  assign side_a_addr_write_bus_ready = aw_space & ~at_max_q;
  assign aw_fire = side_a_addr_write_bus_valid & side_a_addr_write_bus_ready;
  assign b_fire  = side_a_resp_write_bus_valid & side_a_resp_write_bus_ready;

  always_comb begin
    cnt_nxt = cnt;
    if (aw_fire && !b_fire)                 cnt_nxt = cnt + CW'(1);
    else if (b_fire && !aw_fire && cnt != '0) cnt_nxt = cnt - CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt                <= '0;
      at_max_q           <= 1'b0;
      err_resp_underflow <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      at_max_q <= (cnt_nxt == MAX_C);
      if (b_fire && cnt == '0) err_resp_underflow <= 1'b1;
    end
  end

`ifdef COMPOSITE_BUS_SLICE_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      perf_limit_stall <= '0;
    else if (side_a_addr_write_bus_valid && aw_space && at_max_q && perf_limit_stall != 16'hFFFF)
      perf_limit_stall <= perf_limit_stall + 16'd1;
  end
`endif
endmodule

// File: tb/tb_composite_bus_slice.sv
// Bench for composite_bus_slice: queue-based channel model checked every cycle, directed scenarios, random traffic.
module tb_composite_bus_slice;
  localparam int MAXO = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  // channel index: 0 addr_read, 1 addr_write, 2 data_write (a->b); 3 data_read, 4 resp_write (b->a)
  logic [4:0] in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data [5];
  logic [7:0] out_data[5];
  logic       err;
`ifdef COMPOSITE_BUS_SLICE_PERF_EN
  logic [15:0] perf;
`endif
  int n_cmp = 0, n_fail = 0, rst_pulses = 0;

  always #5 clk = ~clk;

  composite_bus_slice #(.ADDR_W(8), .DATA_W(8), .RESP_W(8), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst),
    .side_a_addr_read_bus_data(in_data[0]),   .side_a_addr_read_bus_valid(in_valid[0]),   .side_a_addr_read_bus_ready(in_ready[0]),
    .side_b_addr_read_bus_data(out_data[0]),  .side_b_addr_read_bus_valid(out_valid[0]),  .side_b_addr_read_bus_ready(out_ready[0]),
    .side_a_addr_write_bus_data(in_data[1]),  .side_a_addr_write_bus_valid(in_valid[1]),  .side_a_addr_write_bus_ready(in_ready[1]),
    .side_b_addr_write_bus_data(out_data[1]), .side_b_addr_write_bus_valid(out_valid[1]), .side_b_addr_write_bus_ready(out_ready[1]),
    .side_a_data_write_bus_data(in_data[2]),  .side_a_data_write_bus_valid(in_valid[2]),  .side_a_data_write_bus_ready(in_ready[2]),
    .side_b_data_write_bus_data(out_data[2]), .side_b_data_write_bus_valid(out_valid[2]), .side_b_data_write_bus_ready(out_ready[2]),
    .side_b_data_read_bus_data(in_data[3]),   .side_b_data_read_bus_valid(in_valid[3]),   .side_b_data_read_bus_ready(in_ready[3]),
    .side_a_data_read_bus_data(out_data[3]),  .side_a_data_read_bus_valid(out_valid[3]),  .side_a_data_read_bus_ready(out_ready[3]),
    .side_b_resp_write_bus_data(in_data[4]),  .side_b_resp_write_bus_valid(in_valid[4]),  .side_b_resp_write_bus_ready(in_ready[4]),
    .side_a_resp_write_bus_data(out_data[4]), .side_a_resp_write_bus_valid(out_valid[4]), .side_a_resp_write_bus_ready(out_ready[4]),
    .err_resp_underflow(err)
`ifdef COMPOSITE_BUS_SLICE_PERF_EN
    , .perf_limit_stall(perf)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: each channel is a 2-deep FIFO; the limiter is a plain integer count.
  initial begin : model
    logic [7:0] q[5][$];
    logic [7:0] din[5];
    bit fi[5], fo[5];
    bit started, errm, stall, er, ev;
    int cnt, perf_m, last_p;
    started = 0; errm = 0; cnt = 0; perf_m = 0; last_p = 0;
    forever begin
      @(negedge clk);
      if (last_p != rst_pulses || !rst) begin
        for (int c = 0; c < 5; c++) q[c].delete();
        started = 0; errm = 0; cnt = 0; perf_m = 0; last_p = rst_pulses;
      end
      for (int c = 0; c < 5; c++) begin
        er = started && rst && q[c].size() < 2 && !(c == 1 && cnt == MAXO);
        ev = q[c].size() > 0;
        chk($sformatf("ready_ch%0d", c), 32'(in_ready[c]), 32'(er));
        chk($sformatf("valid_ch%0d", c), 32'(out_valid[c]), 32'(ev));
        if (ev) chk($sformatf("data_ch%0d", c), 32'(out_data[c]), 32'(q[c][0]));
        fi[c] = er && in_valid[c];
        fo[c] = ev && out_ready[c];
        din[c] = in_data[c];
      end
      chk("err_resp_underflow", 32'(err), 32'(errm));
`ifdef COMPOSITE_BUS_SLICE_PERF_EN
      chk("perf_limit_stall", 32'(perf), 32'(perf_m));
`endif
      stall = started && rst && in_valid[1] && q[1].size() < 2 && cnt == MAXO;
      @(posedge clk);
      if (rst) begin
        if (fo[4] && cnt == 0) errm = 1;
        if (fi[1] && !fo[4]) cnt++;
        else if (fo[4] && !fi[1] && cnt > 0) cnt--;
        for (int c = 0; c < 5; c++) begin
          if (fo[c]) void'(q[c].pop_front());
          if (fi[c]) q[c].push_back(din[c]);
        end
        if (stall && perf_m < 65535) perf_m++;
        started = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Asynchronous pulse between edges; call right after tick().
  task automatic pulse_reset();
    #1 rst = 1'b0;
    #1;
    chk("rst_valids", 32'(out_valid), 32'(0));
    chk("rst_readies", 32'(in_ready), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
`ifdef COMPOSITE_BUS_SLICE_PERF_EN
    chk("rst_perf", 32'(perf), 32'(0));
`endif
    rst_pulses++;
    #1 rst = 1'b1;
  endtask

  task automatic step(input int pv4, input int pr);
    logic [4:0] acc;
    @(negedge clk); acc = in_valid & in_ready;
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      if (!in_valid[c] || acc[c]) begin
        in_valid[c] = (int'($urandom_range(99)) < ((c == 4) ? pv4 : 65));
        in_data[c]  = 8'($urandom);
      end
      out_ready[c] = (int'($urandom_range(99)) < pr);
    end
  endtask

  initial begin : stim
    logic [7:0] got[$];
    bit acc, accb, passed;
    int n;
    in_valid = '0; out_ready = '0;
    for (int c = 0; c < 5; c++) in_data[c] = 8'h00;

    // reset state
    #12;
    chk("reset_readies", 32'(in_ready), 32'(0));
    chk("reset_valids", 32'(out_valid), 32'(0));
    chk("reset_err", 32'(err), 32'(0));
    for (int c = 0; c < 5; c++) chk($sformatf("reset_data%0d", c), 32'(out_data[c]), 32'(0));
    @(posedge clk); #3 rst = 1'b1;
    @(negedge clk); chk("release_readies_low", 32'(in_ready), 32'(0));
    @(negedge clk); chk("release_readies_high", 32'(in_ready), 32'h1F);

    // streaming addr_read 01..10
    out_ready = '1;
    tick(); in_valid[0] = 1'b1; in_data[0] = 8'h01;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      chk("stream_ready", 32'(in_ready[0]), 32'(1));
      if (i > 1) chk("stream_out", 32'({out_valid[0], out_data[0]}), 32'({1'b1, 8'(i - 1)}));
      tick();
      if (i < 16) in_data[0] = 8'(i + 1); else in_valid[0] = 1'b0;
    end
    @(negedge clk); chk("stream_last", 32'({out_valid[0], out_data[0]}), 32'h110);

    // backpressure on data_write
    tick(); out_ready[2] = 1'b0; in_valid[2] = 1'b1; in_data[2] = 8'hA5;
    @(negedge clk); chk("bp_ready0", 32'(in_ready[2]), 32'(1));
    tick(); in_data[2] = 8'h5A;
    @(negedge clk); chk("bp_ready1", 32'(in_ready[2]), 32'(1));
    chk("bp_head", 32'({out_valid[2], out_data[2]}), 32'h1A5);
    tick(); in_data[2] = 8'hC3;
    @(negedge clk); chk("bp_ready_drop", 32'(in_ready[2]), 32'(0));
    tick();
    @(negedge clk); chk("bp_hold", 32'({in_ready[2], out_valid[2], out_data[2]}), 32'h1A5);
    tick(); out_ready[2] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      acc = in_valid[2] & in_ready[2];
      if (out_valid[2] && out_ready[2]) got.push_back(out_data[2]);
      tick();
      if (acc) in_valid[2] = 1'b0;
    end
    chk("bp_count", 32'(got.size()), 32'(3));
    if (got.size() == 3) begin
      chk("bp_0", 32'(got[0]), 32'hA5);
      chk("bp_1", 32'(got[1]), 32'h5A);
      chk("bp_2", 32'(got[2]), 32'hC3);
    end

    // reset with two beats buffered in every channel
    out_ready = '0;
    in_valid = '1;
    for (int c = 0; c < 5; c++) in_data[c] = 8'(8'h40 + c * 4);
    tick();
    for (int c = 0; c < 5; c++) in_data[c] = 8'(8'h41 + c * 4);
    tick(); in_valid = '0;
    @(negedge clk);
    chk("full_valids", 32'(out_valid), 32'h1F);
    chk("full_readies", 32'(in_ready), 32'(0));
    tick(); pulse_reset(); out_ready = '1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); chk("no_stale", 32'(out_valid), 32'(0));
    end

    // limiter: five write addresses, no responses
    tick(); in_valid[1] = 1'b1; in_data[1] = 8'h10; out_ready[4] = 1'b1;
    n = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk); acc = in_valid[1] & in_ready[1];
      tick();
      if (acc) begin
        n++;
        if (n < 5) in_data[1] = 8'(8'h10 + n); else in_valid[1] = 1'b0;
      end
    end
    @(negedge clk);
    chk("lim_accepted", 32'(n), 32'(4));
    chk("lim_ready", 32'(in_ready[1]), 32'(0));
`ifdef COMPOSITE_BUS_SLICE_PERF_EN
    chk("lim_perf", 32'(perf), 32'(8));
`endif
    tick(); in_valid[4] = 1'b1; in_data[4] = 8'h77;
    passed = 0;
    for (int k = 0; k < 6 && !passed; k++) begin
      @(negedge clk);
      accb = in_valid[4] & in_ready[4];
      acc  = in_valid[1] & in_ready[1];
      tick();
      if (accb) in_valid[4] = 1'b0;
      if (acc) begin in_valid[1] = 1'b0; passed = 1; end
    end
    chk("lim_fifth_passed", 32'(passed), 32'(1));
    chk("lim_no_err", 32'(err), 32'(0));

    // two buffered responses then simultaneous response/address at the same edge
    out_ready[4] = 1'b0; in_valid[4] = 1'b1; in_data[4] = 8'h81;
    n = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); accb = in_valid[4] & in_ready[4];
      tick();
      if (accb) begin n++; if (n < 2) in_data[4] = 8'h82; else in_valid[4] = 1'b0; end
    end
    chk("sim_buffered", 32'(n), 32'(2));
    in_valid[1] = 1'b1; in_data[1] = 8'h20; out_ready[4] = 1'b1;
    got.delete(); n = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      acc = in_valid[1] & in_ready[1];
      if (out_valid[4] && out_ready[4]) got.push_back(out_data[4]);
      tick();
      if (acc) begin n++; if (n < 3) in_data[1] = 8'(8'h20 + n); end
    end
    chk("sim_aw_accepted", 32'(n), 32'(2));
    chk("sim_resp_count", 32'(got.size()), 32'(2));
    if (got.size() == 2) chk("sim_resp_order", 32'({got[0], got[1]}), 32'h8182);
    chk("sim_no_err", 32'(err), 32'(0));

    // underflow
    pulse_reset(); in_valid[1] = 1'b0;
    tick(); out_ready = '1; in_valid[4] = 1'b1; in_data[4] = 8'h3C;
    got.delete();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      accb = in_valid[4] & in_ready[4];
      if (out_valid[4] && out_ready[4]) got.push_back(out_data[4]);
      tick();
      if (accb) in_valid[4] = 1'b0;
    end
    chk("uf_forwarded", 32'(got.size()), 32'(1));
    if (got.size() == 1) chk("uf_data", 32'(got[0]), 32'h3C);
    chk("uf_err", 32'(err), 32'(1));
    for (int k = 0; k < 5; k++) tick();
    @(negedge clk); chk("uf_sticky", 32'(err), 32'(1));
    tick(); pulse_reset();

    // random traffic with a reset in the middle
    for (int i = 0; i < 2000; i++) begin
      step((i < 1000) ? 20 : 45, (i % 400 < 200) ? 85 : 45);
      if (i == 1000) pulse_reset();
    end
    in_valid = '0;
    for (int k = 0; k < 10; k++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
